// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/execute/memory/writeback with a memory ready handshake.
// Optional CTRL_TRAP_EN macro: illegal opcodes park the FSM in TRAP and raise the extra `trap` output.
module multicycle_controller #(
    parameter int ALUOP_W = 2,
    parameter int ST_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [ST_W-1:0]    state
`ifdef CTRL_TRAP_EN
    ,
    output logic               trap
`endif
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9, S_IEXEC  = 4'd10, S_IWB    = 4'd11,
        S_JUMP   = 4'd12, S_TRAP  = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_LUI   = 2'b11;

    state_e state_q, state_d;

    // funct is reserved for a future ALU decoder; reduce it so it is consumed.
    logic funct_unused;
    assign funct_unused = ^funct;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output and the next state get a default first, so no path can infer a latch.
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_W'(AOP_ADD);

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                unique case (opcode)
                    OP_RTYPE:                  state_d = S_EXEC;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_LUI: state_d = S_IEXEC;
                    OP_J:                      state_d = S_JUMP;
`ifdef CTRL_TRAP_EN
                    default:                   state_d = S_TRAP;
`else
                    default:                   state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(AOP_FUNCT);
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(AOP_SUB);
                pc_src    = 2'b01;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_LUI) ? ALUOP_W'(AOP_LUI) : ALUOP_W'(AOP_ADD);
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    assign state = ST_W'(state_q);
`ifdef CTRL_TRAP_EN
    assign trap = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller; expected states and control words are hand-derived.
// Honours CTRL_TRAP_EN to match the DUT build.
module tb_multicycle_controller;

    localparam int ALUOP_W = 2;
    localparam int ST_W    = 4;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] opcode, funct;
    logic mem_ready, zero;
    logic mem_req, mem_write, iord, ir_write, pc_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [ST_W-1:0] state;
`ifdef CTRL_TRAP_EN
    logic trap;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.ALUOP_W(ALUOP_W), .ST_W(ST_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready), .zero(zero),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state)
`ifdef CTRL_TRAP_EN
        , .trap(trap)
`endif
    );

    // Control word: {mem_req, mem_write, iord, ir_write, pc_write, pc_src[1:0], reg_dst,
    //                mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0]}
    logic [14:0] ctl_act;
    assign ctl_act = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op[1:0]};

    localparam logic [14:0] C_ZERO   = 15'b0_0_0_0_0_00_0_0_0_0_00_00;
    localparam logic [14:0] C_FET_R  = 15'b1_0_0_1_1_00_0_0_0_0_01_00;
    localparam logic [14:0] C_FET_W  = 15'b1_0_0_0_0_00_0_0_0_0_01_00;
    localparam logic [14:0] C_DEC    = 15'b0_0_0_0_0_00_0_0_0_0_11_00;
    localparam logic [14:0] C_MEMADR = 15'b0_0_0_0_0_00_0_0_0_1_10_00;
    localparam logic [14:0] C_MEMRD  = 15'b1_0_1_0_0_00_0_0_0_0_00_00;
    localparam logic [14:0] C_MEMWB  = 15'b0_0_0_0_0_00_0_1_1_0_00_00;
    localparam logic [14:0] C_MEMWR  = 15'b1_1_1_0_0_00_0_0_0_0_00_00;
    localparam logic [14:0] C_EXEC   = 15'b0_0_0_0_0_00_0_0_0_1_00_10;
    localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_00_1_0_1_0_00_00;
    localparam logic [14:0] C_BR_T   = 15'b0_0_0_0_1_01_0_0_0_1_00_01;
    localparam logic [14:0] C_BR_F   = 15'b0_0_0_0_0_01_0_0_0_1_00_01;
    localparam logic [14:0] C_IEX_A  = 15'b0_0_0_0_0_00_0_0_0_1_10_00;
    localparam logic [14:0] C_IEX_L  = 15'b0_0_0_0_0_00_0_0_0_1_10_11;
    localparam logic [14:0] C_IWB    = 15'b0_0_0_0_0_00_0_0_1_0_00_00;
    localparam logic [14:0] C_JUMP   = 15'b0_0_0_0_1_10_0_0_0_0_00_00;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LUI = 6'h0f, OP_J = 6'h02, OP_ILL = 6'h3f;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic [3:0]  st;
        logic [14:0] ctl;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [5:0] op, input logic rdy, input logic z,
                                input logic [3:0] st, input logic [14:0] ctl);
        vec_t v;
        v.op = op; v.rdy = rdy; v.z = z; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, check the settled outputs on the falling edge, then advance.
    task automatic step(input string name, input vec_t v);
        opcode = v.op; mem_ready = v.rdy; zero = v.z;
        @(negedge clk);
        check({name, ".state"}, 32'(state), 32'(v.st));
        check({name, ".ctl"}, 32'(ctl_act), 32'(v.ctl));
`ifdef CTRL_TRAP_EN
        check({name, ".trap"}, 32'(trap), 32'(v.st == 4'd13));
`endif
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset.state", 32'(state), 32'd0);
        check("reset.ctl", 32'(ctl_act), 32'(C_ZERO));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; opcode = 6'h00; funct = 6'h15; mem_ready = 1'b0; zero = 1'b0;

        // LW, all ready: 0,1,2,3,4,5 then FETCH
        add(OP_LW, 1, 0, 4'd0, C_ZERO);
        add(OP_LW, 1, 0, 4'd1, C_FET_R);
        add(OP_LW, 0, 0, 4'd2, C_DEC);
        add(OP_LW, 0, 0, 4'd3, C_MEMADR);
        add(OP_LW, 1, 0, 4'd4, C_MEMRD);
        add(OP_LW, 0, 0, 4'd5, C_MEMWB);
        // SW: FETCH waits 2 cycles, MEMWR waits 3 cycles
        add(OP_SW, 0, 0, 4'd1, C_FET_W);
        add(OP_SW, 0, 0, 4'd1, C_FET_W);
        add(OP_SW, 1, 0, 4'd1, C_FET_R);
        add(OP_SW, 1, 0, 4'd2, C_DEC);
        add(OP_SW, 1, 0, 4'd3, C_MEMADR);
        add(OP_SW, 0, 0, 4'd6, C_MEMWR);
        add(OP_SW, 0, 0, 4'd6, C_MEMWR);
        add(OP_SW, 0, 0, 4'd6, C_MEMWR);
        add(OP_SW, 1, 0, 4'd6, C_MEMWR);
        // BEQ taken, then not taken
        add(OP_BEQ, 1, 0, 4'd1, C_FET_R);
        add(OP_BEQ, 0, 1, 4'd2, C_DEC);
        add(OP_BEQ, 0, 1, 4'd9, C_BR_T);
        add(OP_BEQ, 1, 0, 4'd1, C_FET_R);
        add(OP_BEQ, 1, 1, 4'd2, C_DEC);
        add(OP_BEQ, 1, 0, 4'd9, C_BR_F);
        // R-type
        add(OP_R, 1, 0, 4'd1, C_FET_R);
        add(OP_R, 0, 0, 4'd2, C_DEC);
        add(OP_R, 1, 0, 4'd7, C_EXEC);
        add(OP_R, 0, 0, 4'd8, C_ALUWB);
        // LUI and ADDI
        add(OP_LUI, 1, 0, 4'd1, C_FET_R);
        add(OP_LUI, 0, 0, 4'd2, C_DEC);
        add(OP_LUI, 0, 0, 4'd10, C_IEX_L);
        add(OP_LUI, 0, 0, 4'd11, C_IWB);
        add(OP_ADDI, 1, 0, 4'd1, C_FET_R);
        add(OP_ADDI, 0, 0, 4'd2, C_DEC);
        add(OP_ADDI, 0, 0, 4'd10, C_IEX_A);
        add(OP_ADDI, 0, 0, 4'd11, C_IWB);
        // J
        add(OP_J, 1, 0, 4'd1, C_FET_R);
        add(OP_J, 0, 0, 4'd2, C_DEC);
        add(OP_J, 0, 0, 4'd12, C_JUMP);
        // LW with one MEMRD wait cycle
        add(OP_LW, 1, 0, 4'd1, C_FET_R);
        add(OP_LW, 1, 0, 4'd2, C_DEC);
        add(OP_LW, 1, 0, 4'd3, C_MEMADR);
        add(OP_LW, 0, 0, 4'd4, C_MEMRD);
        add(OP_LW, 1, 0, 4'd4, C_MEMRD);
        add(OP_LW, 1, 0, 4'd5, C_MEMWB);
        // Illegal opcode
        add(OP_ILL, 1, 0, 4'd1, C_FET_R);
        add(OP_ILL, 1, 0, 4'd2, C_DEC);
`ifdef CTRL_TRAP_EN
        add(OP_ILL, 1, 0, 4'd13, C_ZERO);
        add(OP_R, 1, 1, 4'd13, C_ZERO);
        add(OP_LW, 1, 0, 4'd13, C_ZERO);
`else
        add(OP_ILL, 0, 0, 4'd1, C_FET_W);
`endif

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a stalled store must drop the write without a clock edge.
        do_reset();
        v.z = 1'b0;
        v.op = OP_SW; v.rdy = 1'b1; v.st = 4'd0; v.ctl = C_ZERO;   step("rsw.idle", v);
        v.st = 4'd1; v.ctl = C_FET_R;                              step("rsw.fetch", v);
        v.st = 4'd2; v.ctl = C_DEC;                                step("rsw.decode", v);
        v.st = 4'd3; v.ctl = C_MEMADR;                             step("rsw.memadr", v);
        mem_ready = 1'b0;
        @(negedge clk);
        check("rsw.memwr.state", 32'(state), 32'd6);
        check("rsw.memwr.mem_write", 32'(mem_write), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rsw.async.state", 32'(state), 32'd0);
        check("rsw.async.mem_write", 32'(mem_write), 32'd0);
        check("rsw.async.ctl", 32'(ctl_act), 32'(C_ZERO));
`ifdef CTRL_TRAP_EN
        check("rsw.async.trap", 32'(trap), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
